// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the register file with issue scoreboard.
// Holds the default geometry and the hard-wired zero register index.
package reg_file_sb_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_NREG = 32;
    localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Writeback, read, issue and hazard signals of the register file.
// The pipeline drives through master; the register file sits on slave.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = $clog2(DEF_NREG)
);

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [XLEN-1:0] rd_data_a;
    logic [XLEN-1:0] rd_data_b;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic            busy_a;
    logic            busy_b;
    logic            busy_d;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr_a, rd_addr_b,
        output iss_en, iss_rd, flush,
        input  rd_data_a, rd_data_b,
        input  busy_a, busy_b, busy_d
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr_a, rd_addr_b,
        input  iss_en, iss_rd, flush,
        output rd_data_a, rd_data_b,
        output busy_a, busy_b, busy_d
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Issue sets a bit, writeback clears it, and a same-edge issue wins.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            iss_en_i,
    input  logic [AW-1:0]   iss_rd_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    output logic [NREG-1:0] pending_o,
    output logic            busy_d_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end
        if (wr_en_i) begin
            pending_d[wr_addr_i] = 1'b0;
        end
        // Applied last so a new producer survives a retiring old one.
        if (iss_en_i && iss_rd_i != AW'(ZERO_IDX)) begin
            pending_d[iss_rd_i] = 1'b1;
        end
        pending_d[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign busy_d_o  = pending_q[iss_rd_i]
                     & ~(wr_en_i && wr_addr_i == iss_rd_i);

endmodule

// File: rtl/reg_file_sb.sv
// Two-read one-write register file with x0 hard-wired to zero,
// optional writeback forwarding and an issue scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pending;
    logic            fwd_a;
    logic            fwd_b;
    logic            busy_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wr_en && bus.wr_addr != AW'(ZERO_IDX)) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign fwd_a = (BYPASS != 0) && bus.wr_en
                && bus.wr_addr == bus.rd_addr_a;
    assign fwd_b = (BYPASS != 0) && bus.wr_en
                && bus.wr_addr == bus.rd_addr_b;

    always_comb begin
        bus.rd_data_a = regs_q[bus.rd_addr_a];
        if (bus.rd_addr_a == AW'(ZERO_IDX)) begin
            bus.rd_data_a = '0;
        end else if (fwd_a) begin
            bus.rd_data_a = bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data_b = regs_q[bus.rd_addr_b];
        if (bus.rd_addr_b == AW'(ZERO_IDX)) begin
            bus.rd_data_b = '0;
        end else if (fwd_b) begin
            bus.rd_data_b = bus.wr_data;
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (bus.flush),
        .iss_en_i  (bus.iss_en),
        .iss_rd_i  (bus.iss_rd),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .pending_o (pending),
        .busy_d_o  (busy_d)
    );

    // pending[0] is constant 0, so index 0 never reports busy.
    assign bus.busy_a = pending[bus.rd_addr_a] & ~fwd_a;
    assign bus.busy_b = pending[bus.rd_addr_b] & ~fwd_b;
    assign bus.busy_d = busy_d;

endmodule
